writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter NUM_THREADS, default 32, threads per warp (lanes per result).
REQ-002 Parameter REG_WIDTH, default 32, bits per lane value.
REQ-003 Parameter FIFO_DEPTH, default 2, entries per source FIFO; power of two, >=2.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Ports alu_/fpu_/lsu_/sfu_res_valid  input  1 each  result valid from that unit (source index 0..3 in that order).
REQ-007 Ports alu_/fpu_/lsu_/sfu_res_ready  output  1 each  arbiter can accept that unit's result.
REQ-008 Ports *_res_warp  input  6 each  warp id of the result.
REQ-009 Ports *_res_rd  input  5 each  destination register index.
REQ-010 Ports *_res_mask  input  NUM_THREADS each  per-lane write enable.
REQ-011 Ports *_res_data  input  NUM_THREADS*REG_WIDTH each  lane t at [t*REG_WIDTH +: REG_WIDTH].
REQ-012 Port rf_valid  output  1  write request to vector register file.
REQ-013 Port rf_ready  input  1  register file accepts write this cycle.
REQ-014 Ports rf_warp (6), rf_rd (5), rf_mask (NUM_THREADS), rf_data (NUM_THREADS*REG_WIDTH)  output  selected entry fields.
REQ-015 Port rf_src  output  2  source index of the presented entry.
REQ-016 Ports sb_clr_valid (1), sb_clr_warp (6), sb_clr_rd (5)  output  scoreboard release for the retired destination.
REQ-017 Port busy  output  1  any FIFO non-empty.

Function
REQ-018 Each source SHALL own a FIFO_DEPTH-entry FIFO storing {warp, rd, mask, data}; push when *_res_valid && *_res_ready.
REQ-019 *_res_ready SHALL equal (count < FIFO_DEPTH), independent of same-cycle pop; a full FIFO deasserts ready even while popping.
REQ-020 Push-to-rf_valid latency SHALL be 1 cycle minimum (entry pushed in cycle N is visible at earliest in N+1); no combinational input-to-output path.
REQ-021 rf_valid SHALL be high whenever any FIFO is non-empty, and SHALL NOT depend on rf_ready.
REQ-022 Selection SHALL be round-robin: search sources starting at pointer rr_ptr (2 bits), first non-empty wins.
REQ-023 Transfer occurs when rf_valid && rf_ready: selected FIFO pops, rr_ptr <= grant+1 (mod 4).
REQ-024 While rf_valid && !rf_ready, grant and all rf_* outputs SHALL hold stable (grant locked) until transfer, even if higher-priority sources become non-empty.
REQ-025 sb_clr_valid SHALL equal rf_valid && rf_ready, with sb_clr_warp/sb_clr_rd equal to rf_warp/rf_rd that cycle.
REQ-026 Entries with mask == 0 SHALL still be presented and retired (rf_mask = 0, scoreboard still cleared).
REQ-027 Simultaneous push and pop on one FIFO SHALL leave count unchanged and preserve order; FIFO pointers wrap mod FIFO_DEPTH.
REQ-028 Per-source order SHALL be preserved; no ordering guaranteed across sources.
REQ-029 When all FIFOs empty: rf_valid = 0, sb_clr_valid = 0, rf_* data outputs = 0, rr_ptr unchanged.
REQ-030 busy SHALL be the OR of all FIFO non-empty flags (registered state).

Reset
REQ-031 On rst high at a clock edge: all FIFO counts and pointers = 0, rr_ptr = 0, grant lock cleared; in-flight entries discarded.
REQ-032 During and the cycle after reset: rf_valid = 0, sb_clr_valid = 0, busy = 0, all *_res_ready = 1, all rf_* outputs = 0.
REQ-033 Reset mid-stall SHALL drop the locked entry without a transfer or scoreboard clear.

Verification
REQ-034 Single ALU result warp=3 rd=7 mask=all-ones, rf_ready=1 -> rf_valid next cycle, rf_src=0, sb_clr warp=3 rd=7 same cycle, busy=0 after.
REQ-035 All four units push one result same cycle, rf_ready=1, rr_ptr=0 -> retire order src 0,1,2,3 on four consecutive cycles, rr_ptr=0 at end.
REQ-036 LSU pushes 3 results back-to-back with rf_ready=0, FIFO_DEPTH=2 -> lsu_res_ready drops after 2nd push; 3rd held; on rf_ready=1 entries retire in push order.
REQ-037 ALU entry stalled (rf_ready=0) for 5 cycles while SFU becomes non-empty -> rf_src stays 0 and outputs stable; ALU retires first, then SFU.
REQ-038 FPU result mask=0 -> rf_valid with rf_mask=0, sb_clr_valid=1 on transfer.
REQ-039 rst asserted with 2 entries queued and one stalled -> next cycle rf_valid=0, busy=0, all ready=1, no sb_clr_valid pulse.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: four result sources (ALU, FPU, LSU, SFU) each feed a
// small FIFO. A round-robin arbiter then presents one entry at a time to the
// vector register file and releases the scoreboard entry for the destination
// register when the write retires. Once the arbiter presents an entry, it
// keeps presenting that same entry until the register file accepts it.
module writeback_arbiter #(
   parameter int NUM_THREADS = 32,
   parameter int REG_WIDTH   = 32,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic                             clk,
   input  logic                             rst,

   input  logic                             alu_res_valid,
   output logic                             alu_res_ready,
   input  logic [5:0]                       alu_res_warp,
   input  logic [4:0]                       alu_res_rd,
   input  logic [NUM_THREADS-1:0]           alu_res_mask,
   input  logic [NUM_THREADS*REG_WIDTH-1:0] alu_res_data,

   input  logic                             fpu_res_valid,
   output logic                             fpu_res_ready,
   input  logic [5:0]                       fpu_res_warp,
   input  logic [4:0]                       fpu_res_rd,
   input  logic [NUM_THREADS-1:0]           fpu_res_mask,
   input  logic [NUM_THREADS*REG_WIDTH-1:0] fpu_res_data,

   input  logic                             lsu_res_valid,
   output logic                             lsu_res_ready,
   input  logic [5:0]                       lsu_res_warp,
   input  logic [4:0]                       lsu_res_rd,
   input  logic [NUM_THREADS-1:0]           lsu_res_mask,
   input  logic [NUM_THREADS*REG_WIDTH-1:0] lsu_res_data,

   input  logic                             sfu_res_valid,
   output logic                             sfu_res_ready,
   input  logic [5:0]                       sfu_res_warp,
   input  logic [4:0]                       sfu_res_rd,
   input  logic [NUM_THREADS-1:0]           sfu_res_mask,
   input  logic [NUM_THREADS*REG_WIDTH-1:0] sfu_res_data,

   output logic                             rf_valid,
   input  logic                             rf_ready,
   output logic [5:0]                       rf_warp,
   output logic [4:0]                       rf_rd,
   output logic [NUM_THREADS-1:0]           rf_mask,
   output logic [NUM_THREADS*REG_WIDTH-1:0] rf_data,
   output logic [1:0]                       rf_src,

   output logic                             sb_clr_valid,
   output logic [5:0]                       sb_clr_warp,
   output logic [4:0]                       sb_clr_rd,

   output logic                             busy
);

   localparam int NS = 4;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int DW = NUM_THREADS * REG_WIDTH;

   typedef struct packed {
      logic [5:0]             warp;
      logic [4:0]             rd;
      logic [NUM_THREADS-1:0] mask;
      logic [DW-1:0]          data;
   } entry_t;

   logic [NS-1:0] in_valid;
   entry_t        in_entry [NS];
   entry_t        head     [NS];
   logic [NS-1:0] nonempty;
   logic [NS-1:0] not_full;

   logic [1:0]    rr_ptr;
   logic          lock_q;
   logic [1:0]    lock_src_q;
   logic [1:0]    search_grant;
   logic [1:0]    grant;
   logic          any_ne;
   logic          xfer;

   // Gather the four source ports into index-addressable form (0=ALU .. 3=SFU).
   assign in_valid    = {sfu_res_valid, lsu_res_valid, fpu_res_valid, alu_res_valid};
   assign in_entry[0] = '{alu_res_warp, alu_res_rd, alu_res_mask, alu_res_data};
   assign in_entry[1] = '{fpu_res_warp, fpu_res_rd, fpu_res_mask, fpu_res_data};
   assign in_entry[2] = '{lsu_res_warp, lsu_res_rd, lsu_res_mask, lsu_res_data};
   assign in_entry[3] = '{sfu_res_warp, sfu_res_rd, sfu_res_mask, sfu_res_data};

   // Ready depends only on the registered count. A full FIFO therefore stays
   // not-ready even in a cycle where it is popped. During reset every source
   // is shown as ready, because the queues are being emptied.
   assign alu_res_ready = rst | not_full[0];
   assign fpu_res_ready = rst | not_full[1];
   assign lsu_res_ready = rst | not_full[2];
   assign sfu_res_ready = rst | not_full[3];

   for (genvar s = 0; s < NS; s++) begin : g_fifo
      entry_t         mem [FIFO_DEPTH];
      logic [PW-1:0]  wr_ptr;
      logic [PW-1:0]  rd_ptr;
      logic [CW-1:0]  count;
      logic           push;
      logic           pop;

      assign not_full[s] = (count < CW'(FIFO_DEPTH));
      assign nonempty[s] = (count != '0);
      assign push        = in_valid[s] && not_full[s];
      assign pop         = xfer && (grant == 2'(s));
      assign head[s]     = mem[rd_ptr];

      // Pointer and occupancy bookkeeping. Both pointers wrap naturally
      // because the depth is a power of two.
      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end

      // Entry storage.
      // NOTE: storage has no reset. The count alone decides what is valid, so clearing the array would only add reset fan-out.
      always_ff @(posedge clk) begin
         if (push) mem[wr_ptr] <= in_entry[s];
      end
   end

   // Round-robin search: starting at rr_ptr, the first non-empty source wins.
   always_comb begin
      // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
      logic       found;
      logic [1:0] idx;
      search_grant = rr_ptr;
      found        = 1'b0;
      idx          = '0;
      for (int i = 0; i < NS; i++) begin
         idx = rr_ptr + 2'(i);
         if (!found && nonempty[idx]) begin
            search_grant = idx;
            found        = 1'b1;
         end
      end
   end

   assign grant    = lock_q ? lock_src_q : search_grant;
   assign any_ne   = |nonempty;
   assign rf_valid = any_ne && !rst;
   assign xfer     = rf_valid && rf_ready;
   assign busy     = any_ne && !rst;

   // Arbitration state. The pointer advances past the winner on each transfer.
   // The grant is locked while the register file stalls.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         rr_ptr     <= '0;
         lock_q     <= 1'b0;
         lock_src_q <= '0;
      end else if (xfer) begin
         rr_ptr <= grant + 2'd1;
         lock_q <= 1'b0;
      end else if (rf_valid) begin
         lock_q     <= 1'b1;
         lock_src_q <= grant;
      end
   end

   // Present the granted head entry. All fields read as zero when nothing is queued.
   always_comb begin
      rf_warp = '0;
      rf_rd   = '0;
      rf_mask = '0;
      rf_data = '0;
      rf_src  = '0;
      if (rf_valid) begin
         rf_warp = head[grant].warp;
         rf_rd   = head[grant].rd;
         rf_mask = head[grant].mask;
         rf_data = head[grant].data;
         rf_src  = grant;
      end
   end

   // The scoreboard release for the destination goes out with the write that retires it.
   assign sb_clr_valid = xfer;
   assign sb_clr_warp  = rf_warp;
   assign sb_clr_rd    = rf_rd;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter. A table of per-cycle stimulus and
// expected outputs is applied first. A hand-written streaming sequence then
// checks FIFO pointer wrap at full throughput.
module tb_writeback_arbiter;

   localparam int NT = 4;
   localparam int RW = 8;
   localparam int DW = NT * RW;

   logic          clk = 1'b0;
   logic          rst;
   logic          u_valid [4];
   logic          u_ready [4];
   logic [5:0]    u_warp  [4];
   logic [4:0]    u_rd    [4];
   logic [NT-1:0] u_mask  [4];
   logic [DW-1:0] u_data  [4];

   logic          rf_valid, rf_ready;
   logic [5:0]    rf_warp;
   logic [4:0]    rf_rd;
   logic [NT-1:0] rf_mask;
   logic [DW-1:0] rf_data;
   logic [1:0]    rf_src;
   logic          sb_clr_valid;
   logic [5:0]    sb_clr_warp;
   logic [4:0]    sb_clr_rd;
   logic          busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   writeback_arbiter #(.NUM_THREADS(NT), .REG_WIDTH(RW), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .alu_res_valid(u_valid[0]), .alu_res_ready(u_ready[0]), .alu_res_warp(u_warp[0]),
      .alu_res_rd(u_rd[0]), .alu_res_mask(u_mask[0]), .alu_res_data(u_data[0]),
      .fpu_res_valid(u_valid[1]), .fpu_res_ready(u_ready[1]), .fpu_res_warp(u_warp[1]),
      .fpu_res_rd(u_rd[1]), .fpu_res_mask(u_mask[1]), .fpu_res_data(u_data[1]),
      .lsu_res_valid(u_valid[2]), .lsu_res_ready(u_ready[2]), .lsu_res_warp(u_warp[2]),
      .lsu_res_rd(u_rd[2]), .lsu_res_mask(u_mask[2]), .lsu_res_data(u_data[2]),
      .sfu_res_valid(u_valid[3]), .sfu_res_ready(u_ready[3]), .sfu_res_warp(u_warp[3]),
      .sfu_res_rd(u_rd[3]), .sfu_res_mask(u_mask[3]), .sfu_res_data(u_data[3]),
      .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_warp(rf_warp), .rf_rd(rf_rd),
      .rf_mask(rf_mask), .rf_data(rf_data), .rf_src(rf_src),
      .sb_clr_valid(sb_clr_valid), .sb_clr_warp(sb_clr_warp), .sb_clr_rd(sb_clr_rd),
      .busy(busy)
   );

   typedef struct {
      logic       rst;
      logic [3:0] push;
      logic [3:0] tag;
      logic [3:0] mask;
      logic       rdy;
      logic       e_valid;
      logic [1:0] e_src;
      logic [5:0] e_warp;
      logic [4:0] e_rd;
      logic [3:0] e_mask;
      logic [3:0] e_ready;
      logic       e_busy;
   } vec_t;

   vec_t vecs[$];

   // Lane t of a result from source s with tag g is {s, g, t}.
   function automatic logic [DW-1:0] mk_data(input logic [1:0] s, input logic [3:0] tag);
      logic [DW-1:0] d;
      d = '0;
      for (int t = 0; t < NT; t++) d[t*RW +: RW] = {s, tag, 2'(t)};
      return d;
   endfunction

   function automatic vec_t mkv(input logic r, input logic [3:0] push, input logic [3:0] tag,
                                input logic [3:0] mask, input logic rdy, input logic ev,
                                input logic [1:0] es, input logic [5:0] ew, input logic [4:0] er,
                                input logic [3:0] em, input logic [3:0] erdy, input logic eb);
      vec_t v;
      v.rst = r; v.push = push; v.tag = tag; v.mask = mask; v.rdy = rdy;
      v.e_valid = ev; v.e_src = es; v.e_warp = ew; v.e_rd = er; v.e_mask = em;
      v.e_ready = erdy; v.e_busy = eb;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every pushing source gets warp = {src, tag}, rd = tag + 4, and the given mask.
   task automatic drive(input logic r, input logic [3:0] push, input logic [3:0] tag,
                        input logic [3:0] mask, input logic rdy);
      rst      = r;
      rf_ready = rdy;
      for (int s = 0; s < 4; s++) begin
         u_valid[s] = push[s];
         u_warp[s]  = {2'(s), tag};
         u_rd[s]    = 5'(tag) + 5'd4;
         u_mask[s]  = mask;
         u_data[s]  = mk_data(2'(s), tag);
      end
   endtask

   task automatic check_outputs(input string tag, input logic ev, input logic [1:0] es,
                                input logic [5:0] ew, input logic [4:0] er, input logic [3:0] em,
                                input logic [3:0] erdy, input logic eb, input logic rdy);
      logic [DW-1:0] ed;
      ed = ev ? mk_data(es, ew[3:0]) : '0;
      check({tag, " rf_valid"},     64'(rf_valid), 64'(ev));
      check({tag, " rf_src"},       64'(rf_src),   64'(ev ? es : 2'd0));
      check({tag, " rf_warp"},      64'(rf_warp),  64'(ev ? ew : 6'd0));
      check({tag, " rf_rd"},        64'(rf_rd),    64'(ev ? er : 5'd0));
      check({tag, " rf_mask"},      64'(rf_mask),  64'(ev ? em : 4'd0));
      check({tag, " rf_data"},      64'(rf_data),  64'(ed));
      check({tag, " sb_clr_valid"}, 64'(sb_clr_valid), 64'(ev && rdy));
      check({tag, " sb_clr_warp"},  64'(sb_clr_warp),  64'(ev ? ew : 6'd0));
      check({tag, " sb_clr_rd"},    64'(sb_clr_rd),    64'(ev ? er : 5'd0));
      check({tag, " ready"},
            64'({u_ready[3], u_ready[2], u_ready[1], u_ready[0]}), 64'(erdy));
      check({tag, " busy"}, 64'(busy), 64'(eb));
   endtask

   initial begin
      // Single ALU result, warp 3 rd 7.
      vecs.push_back(mkv(0, 4'b0001, 4'd3, 4'hF, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 0, 6'd3,  5'd7,  4'hF, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      // Reset, then all four units push together and retire 0,1,2,3.
      vecs.push_back(mkv(1, 4'b0000, 4'd0, 4'h0, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      vecs.push_back(mkv(0, 4'b1111, 4'd5, 4'hA, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 0, 6'd5,  5'd9,  4'hA, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 1, 6'd21, 5'd9,  4'hA, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 2, 6'd37, 5'd9,  4'hA, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 3, 6'd53, 5'd9,  4'hA, 4'hF, 1));
      // Pointer back at 0: ALU beats FPU.
      vecs.push_back(mkv(0, 4'b0011, 4'd2, 4'hF, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 0, 6'd2,  5'd6,  4'hF, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 1, 6'd18, 5'd6,  4'hF, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      // LSU back-to-back into a stalled register file; third push held off.
      vecs.push_back(mkv(0, 4'b0100, 4'd1, 4'hF, 0, 0, 0, 0,     0,     0,    4'hF, 0));
      vecs.push_back(mkv(0, 4'b0100, 4'd2, 4'hF, 0, 1, 2, 6'd33, 5'd5,  4'hF, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0100, 4'd3, 4'hF, 0, 1, 2, 6'd33, 5'd5,  4'hF, 4'hB, 1));
      vecs.push_back(mkv(0, 4'b0100, 4'd3, 4'hF, 1, 1, 2, 6'd33, 5'd5,  4'hF, 4'hB, 1));
      vecs.push_back(mkv(0, 4'b0100, 4'd3, 4'hF, 1, 1, 2, 6'd34, 5'd6,  4'hF, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 2, 6'd35, 5'd7,  4'hF, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      // ALU stalled 5 cycles while SFU fills. The pointer sits at 3, but the lock keeps the ALU.
      vecs.push_back(mkv(0, 4'b0001, 4'd4, 4'hF, 0, 0, 0, 0,     0,     0,    4'hF, 0));
      vecs.push_back(mkv(0, 4'b1000, 4'd6, 4'hF, 0, 1, 0, 6'd4,  5'd8,  4'hF, 4'hF, 1));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 0, 1, 0, 6'd4, 5'd8, 4'hF, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 0, 6'd4,  5'd8,  4'hF, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 3, 6'd54, 5'd10, 4'hF, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      // FPU result with an all-zero mask still retires.
      vecs.push_back(mkv(0, 4'b0010, 4'd9, 4'h0, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 1, 1, 6'd25, 5'd13, 4'h0, 4'hF, 1));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      // Reset while entries are queued and one is stalled.
      vecs.push_back(mkv(0, 4'b0011, 4'd7, 4'hF, 0, 0, 0, 0,     0,     0,    4'hF, 0));
      vecs.push_back(mkv(0, 4'b0001, 4'd8, 4'hF, 0, 1, 0, 6'd7,  5'd11, 4'hF, 4'hF, 1));
      vecs.push_back(mkv(1, 4'b0000, 4'd0, 4'h0, 1, 0, 0, 0,     0,     0,    4'hF, 0));
      vecs.push_back(mkv(0, 4'b0000, 4'd0, 4'h0, 1, 0, 0, 0,     0,     0,    4'hF, 0));

      drive(1, 4'b0000, 4'd0, 4'h0, 0);
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         drive(vecs[i].rst, vecs[i].push, vecs[i].tag, vecs[i].mask, vecs[i].rdy);
         @(negedge clk);
         check_outputs($sformatf("row%0d", i), vecs[i].e_valid, vecs[i].e_src, vecs[i].e_warp,
                       vecs[i].e_rd, vecs[i].e_mask, vecs[i].e_ready, vecs[i].e_busy,
                       vecs[i].rdy);
      end

      // Streaming: the ALU pushes every cycle while the register file always
      // accepts. Each entry retires one cycle after its push, and ready never drops.
      for (int k = 0; k <= 6; k++) begin
         @(posedge clk);
         #1;
         drive(0, (k < 6) ? 4'b0001 : 4'b0000, 4'(k), 4'hF, 1);
         @(negedge clk);
         if (k == 0)
            check_outputs("stream0", 0, 0, 0, 0, 0, 4'hF, 0, 1);
         else
            check_outputs($sformatf("stream%0d", k), 1, 0, 6'(k - 1), 5'(k + 3), 4'hF, 4'hF, 1, 1);
      end
      @(posedge clk);
      #1;
      drive(0, 4'b0000, 4'd0, 4'h0, 1);
      @(negedge clk);
      check_outputs("stream_end", 0, 0, 0, 0, 0, 4'hF, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
